// File: rtl/demux_oh_stream.sv
// 1-to-N one-hot demultiplexer with per-lane single-entry output buffers and valid/ready flow control.
// Optional macro DEMUX_OH_DROP_CNT_EN adds a saturating 16-bit count of dropped non-one-hot beats.
module demux_oh_stream #(
   parameter int unsigned OutputWidth = 8,
   parameter int unsigned DataWidth   = 8
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic                                   valid_i,
   output logic                                   ready_o,
   input  logic [OutputWidth-1:0]                 sel_i,
   input  logic [DataWidth-1:0]                   data_i,
   output logic [OutputWidth-1:0]                 valid_o,
   input  logic [OutputWidth-1:0]                 ready_i,
   output logic [OutputWidth-1:0][DataWidth-1:0]  data_o,
   output logic                                   err_o
`ifdef DEMUX_OH_DROP_CNT_EN
   ,
   output logic [15:0]                            drop_cnt_o
`endif
);

   localparam logic [OutputWidth-1:0] SelOne = {{(OutputWidth-1){1'b0}}, 1'b1};

   logic [OutputWidth-1:0]                valid_q, valid_d;
   logic [OutputWidth-1:0][DataWidth-1:0] data_q, data_d;
   logic                                  err_q, err_d;
   logic                                  sel_legal;
   logic [OutputWidth-1:0]                fill;
   logic [OutputWidth-1:0]                drain;

   // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
   assign sel_legal = (sel_i != '0) && ((sel_i & (sel_i - SelOne)) == '0);

   // A full lane that drains this cycle can take a new beat in the same cycle.
   assign ready_o = !sel_legal || (|(sel_i & (~valid_q | ready_i)));

   always_comb begin
      fill    = (valid_i && sel_legal && ready_o) ? sel_i : '0;
      drain   = valid_q & ready_i;
      valid_d = fill | (valid_q & ~drain);
      data_d  = data_q;
      for (int k = 0; k < int'(OutputWidth); k++) begin
         if (fill[k]) begin
            data_d[k] = data_i;
         end
      end
      err_d = valid_i && !sel_legal;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign err_o   = err_q;

`ifdef DEMUX_OH_DROP_CNT_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (err_d && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         drop_cnt_q <= 16'd0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_demux_oh_stream.sv
// Scoreboard bench for demux_oh_stream: per-lane FIFO golden model, directed cases then randomized beats.
module tb_demux_oh_stream;

   localparam int N = 8;
   localparam int W = 8;

   logic                 clk_i = 1'b0;
   logic                 rst_ni = 1'b0;
   logic                 valid_i = 1'b0;
   logic                 ready_o;
   logic [N-1:0]         sel_i = '0;
   logic [W-1:0]         data_i = '0;
   logic [N-1:0]         valid_o;
   logic [N-1:0]         ready_i = '0;
   logic [N-1:0][W-1:0]  data_o;
   logic                 err_o;
`ifdef DEMUX_OH_DROP_CNT_EN
   logic [15:0]          drop_cnt_o;
`endif

   demux_oh_stream #(.OutputWidth(N), .DataWidth(W)) dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .sel_i   (sel_i),
      .data_i  (data_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .data_o  (data_o),
      .err_o   (err_o)
`ifdef DEMUX_OH_DROP_CNT_EN
      ,
      .drop_cnt_o (drop_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int          checks = 0;
   int          errors = 0;
   logic [W-1:0] lane_q[N][$];
   logic [N-1:0] full_m = '0;
   logic         err_exp = 1'b0;
   int           drop_exp = 0;
   logic         mon_en = 1'b0;
   int           accepted = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: 2 time units after each edge, compares outputs with the model and retires drained beats.
   initial begin
      forever begin
         @(posedge clk_i);
         #2;
         if (mon_en) begin
            for (int k = 0; k < N; k++) begin
               full_m[k] = (lane_q[k].size() > 0);
               check($sformatf("valid_o[%0d]", k), {31'd0, valid_o[k]}, {31'd0, full_m[k]});
               if (full_m[k]) begin
                  check($sformatf("data_o[%0d]", k), {24'd0, data_o[k]}, {24'd0, lane_q[k][0]});
                  if (ready_i[k]) void'(lane_q[k].pop_front());
               end
            end
            check("err_o", {31'd0, err_o}, {31'd0, err_exp});
`ifdef DEMUX_OH_DROP_CNT_EN
            check("drop_cnt_o", {16'd0, drop_cnt_o}, drop_exp);
`endif
         end
      end
   end

   // One cycle of stimulus; the expected acceptance comes from the model's lane occupancy.
   task automatic beat(input logic v, input logic [N-1:0] s, input logic [W-1:0] d, input logic [N-1:0] r);
      logic legal;
      logic exp_rdy;
      int   lane;
      @(posedge clk_i);
      #1;
      valid_i = v; sel_i = s; data_i = d; ready_i = r;
      #2;
      legal = ($countones(s) == 1);
      lane = 0;
      for (int k = 0; k < N; k++) if (s[k]) lane = k;
      exp_rdy = legal ? (!full_m[lane] || r[lane]) : 1'b1;
      check("ready_o", {31'd0, ready_o}, {31'd0, exp_rdy});
      err_exp = v && !legal;
      if (v && !legal && drop_exp < 65535) drop_exp++;
      if (v && legal && exp_rdy) begin
         lane_q[lane].push_back(d);
         accepted++;
      end
   endtask

   task automatic mid_reset();
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      #2;
      rst_ni = 1'b0;
      for (int k = 0; k < N; k++) lane_q[k].delete();
      err_exp = 1'b0;
      drop_exp = 0;
      #1;
      check("reset valid_o", {24'd0, valid_o}, 32'd0);
      check("reset err_o", {31'd0, err_o}, 32'd0);
      check("reset data_o", {24'd0, data_o[$urandom_range(0, N-1)]}, 32'd0);
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
   endtask

   initial begin
      logic [N-1:0] s;
      logic [N-1:0] onehot;
      rst_ni = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      check("idle valid_o", {24'd0, valid_o}, 32'd0);
      check("idle err_o", {31'd0, err_o}, 32'd0);
      for (int k = 0; k < N; k++) begin
         check($sformatf("idle data_o[%0d]", k), {24'd0, data_o[k]}, 32'd0);
         onehot = '0;
         onehot[k] = 1'b1;
         sel_i = onehot;
         #0;
         check($sformatf("idle ready_o sel%0d", k), {31'd0, ready_o}, 32'd1);
      end
      rst_ni = 1'b1;
      mon_en = 1'b1;

      beat(1'b1, 8'h04, 8'hA5, 8'h00);
      repeat (5) beat(1'b0, 8'h00, 8'h00, 8'h00);
      beat(1'b0, 8'h00, 8'h00, 8'h04);
      beat(1'b0, 8'h00, 8'h00, 8'h00);

      beat(1'b1, 8'h04, 8'h5A, 8'h00);
      beat(1'b1, 8'h04, 8'h99, 8'h00);
      beat(1'b1, 8'h04, 8'h3C, 8'h04);
      beat(1'b0, 8'h00, 8'h00, 8'h00);
      beat(1'b0, 8'h00, 8'h00, 8'h04);

      beat(1'b1, 8'h01, 8'h11, 8'h00);
      beat(1'b1, 8'h80, 8'h77, 8'h00);
      beat(1'b0, 8'h00, 8'h00, 8'h80);
      repeat (2) beat(1'b0, 8'h00, 8'h00, 8'h00);
      beat(1'b0, 8'h00, 8'h00, 8'h01);

      beat(1'b1, 8'h00, 8'hE1, 8'h00);
      beat(1'b1, 8'h03, 8'hE2, 8'h00);
      repeat (2) beat(1'b0, 8'h00, 8'h00, 8'h00);

      for (int i = 0; i < 10000; i++) begin
         if (i == 5000) mid_reset();
         if ($urandom_range(0, 9) != 0) begin
            s = '0;
            s[$urandom_range(0, N-1)] = 1'b1;
         end else begin
            s = N'($urandom);
         end
         beat($urandom_range(0, 3) != 0, s, W'($urandom), N'($urandom));
      end

      repeat (3) beat(1'b0, 8'h00, 8'h00, 8'hFF);
      for (int k = 0; k < N; k++) check($sformatf("leftover lane %0d", k), lane_q[k].size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/demux_oh_stream.md
Name: demux_oh_stream

Overview:
- 1-to-N one-hot demultiplexer with valid/ready flow control; the distribution counterpart of the one-hot mux cell.
- Routes one input beat to the output lane chosen by a one-hot select and buffers it in that lane's single-entry register until the consumer drains it.
- Lives in commoncell/Basic; used to fan issue or response streams out to N one-hot-addressed consumers.

Parameters:
- OutputWidth, 8, number of output lanes (N >= 2).
- DataWidth, 8, payload width in bits.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- valid_i  input  1  input beat valid.
- ready_o  output  1  input beat accepted when valid_i && ready_o.
- sel_i  input  OutputWidth  destination lane, one-hot; sampled only with valid_i.
- data_i  input  DataWidth  input payload.
- valid_o  output  OutputWidth  per-lane output valid.
- ready_i  input  OutputWidth  per-lane consumer ready.
- data_o  output  OutputWidth x DataWidth  per-lane payload, packed [OutputWidth-1:0][DataWidth-1:0].
- err_o  output  1  one-cycle registered pulse when a non-one-hot select was dropped.

Behaviour:
- Reset (async assert, sync deassert by the caller): all valid_o = 0, all data_o = 0, err_o = 0. Reset mid-transfer discards every buffered beat. The next beat is accepted on the first edge after deassertion.
- Lane k state is full_k = valid_o[k]. Lane k drains on a rising edge when valid_o[k] && ready_i[k].
- sel_i is legal when popcount(sel_i) == 1.
- ready_o, combinational:
  - Legal sel_i selecting lane k: ready_o = !full_k || ready_i[k], so a full lane that drains this cycle accepts a new beat in the same cycle.
  - Illegal sel_i (zero or multi-hot): ready_o = 1.
  - ready_o does not depend on valid_i.
- Accept of a legal beat to lane k: on the edge, data_o[k] <= data_i and valid_o[k] <= 1. Latency is 1 cycle from accept to valid_o. Simultaneous drain and fill of lane k gives back-to-back throughput of 1 beat/cycle per lane.
- Drain without fill: valid_o[k] <= 0. data_o[k] keeps its last value.
- Hold: while valid_o[k] && !ready_i[k], data_o[k] and valid_o[k] must not change.
- Illegal beat (valid_i && illegal sel_i): consumed and dropped. No lane changes. err_o = 1 for exactly the next cycle. Consecutive illegal beats keep err_o high for the same number of cycles.
- Lanes are independent. Draining lane j never affects lane k.
- No combinational path from ready_i[j] to valid_o.
- The only combinational paths are sel_i -> ready_o and ready_i -> ready_o.
- Unselected lanes ignore data_i.

Optional Feature:
- Macro: DEMUX_OH_DROP_CNT_EN.
- Defined:
  - Adds output port drop_cnt_o, 16 bits.
  - Counts dropped illegal beats; increments on the same edge that sets err_o.
  - Saturates at 16'hFFFF.
  - Reset value 0.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: hold rst_ni = 0 for 3 cycles -> valid_o = 8'h00, data_o all 0, err_o = 0, ready_o = 1 for any legal sel_i.
- Single routed beat: sel_i = 8'b0000_0100, data_i = 8'hA5, ready_i = 0 -> next cycle valid_o = 8'b0000_0100, data_o[2] = 8'hA5. The beat holds for 5 cycles. Raise ready_i[2] -> valid_o[2] = 0 one cycle later.
- Backpressure and streaming:
  - Lane 2 full, ready_i[2] = 0, new beat to lane 2 -> ready_o = 0, data_o[2] unchanged.
  - Raise ready_i[2] with a new beat 8'h3C -> accepted that same cycle; data_o[2] = 8'h3C next cycle, valid_o[2] stays 1.
- Lane independence: fill lane 0 (8'h11) and lane 7 (8'h77) on consecutive cycles, drain only lane 7 -> lane 0 still holds 8'h11 with valid_o[0] = 1.
- Illegal select: sel_i = 8'h00 then 8'h03, valid_i = 1 -> ready_o = 1 both cycles, no valid_o change, err_o high for exactly 2 cycles. With DEMUX_OH_DROP_CNT_EN, drop_cnt_o = 2.
- Randomized run, 10000 beats: one-hot random sel_i, random ready_i -> every accepted beat appears exactly once, in order, on its lane, compared against a per-lane FIFO golden model. Assert rst_ni mid-run -> all valid_o = 0 immediately.
